// File: rtl/fc_tx_credit_gate_pkg.sv
// Shared types and widths for the transmit-side flow-control credit gate.
package fc_tx_credit_gate_pkg;

  localparam int FC_HDR_W     = 8;
  localparam int FC_DATA_W    = 12;
  localparam int FC_NUM_TYPES = 3;

  typedef enum logic [1:0] {
    FC_MWR = 2'b00,
    FC_MRD = 2'b01,
    FC_CPL = 2'b10
  } fc_type_e;

  typedef enum logic {
    FC_INIT   = 1'b0,
    FC_ACTIVE = 1'b1
  } fc_state_e;

  function automatic logic fc_type_valid(input logic [1:0] t);
    return t != 2'b11;
  endfunction

endpackage

// File: rtl/fc_tx_credit_slot.sv
// Credit limit / credits consumed bookkeeping for one TLP type, with
// modular-window sufficiency checks for header and data credit.
module fc_tx_credit_slot #(
  parameter int HDR_W  = 8,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_i,
  input  logic              update_i,
  input  logic              consume_i,
  input  logic [HDR_W-1:0]  adv_hdr_i,
  input  logic [DATA_W-1:0] adv_data_i,
  input  logic [DATA_W-1:0] req_data_i,
  output logic              hdr_ok_o,
  output logic              data_ok_o,
  output logic              update_err_o
);

  localparam logic [HDR_W-1:0]  HDR_HALF  = {1'b1, {(HDR_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] DATA_HALF = {1'b1, {(DATA_W-1){1'b0}}};

  logic [HDR_W-1:0]  cl_h_q, cc_h_q, cc_h_d;
  logic [DATA_W-1:0] cl_d_q, cc_d_q, cc_d_d;
  logic              inf_h_q, inf_d_q;
  logic [HDR_W-1:0]  hdr_room, upd_hdr_room;
  logic [DATA_W-1:0] data_room, upd_data_room;

  always_comb begin
    cc_h_d        = consume_i ? cc_h_q + HDR_W'(1) : cc_h_q;
    cc_d_d        = consume_i ? cc_d_q + req_data_i : cc_d_q;
    hdr_room      = cl_h_q - cc_h_q - HDR_W'(1);
    data_room     = cl_d_q - cc_d_q - req_data_i;
    // Window check on a new limit is taken against the post-consume count.
    upd_hdr_room  = adv_hdr_i - cc_h_d;
    upd_data_room = adv_data_i - cc_d_d;
    hdr_ok_o      = inf_h_q | (hdr_room <= HDR_HALF);
    data_ok_o     = inf_d_q | (data_room <= DATA_HALF);
    update_err_o  = update_i & ((~inf_h_q & (upd_hdr_room > HDR_HALF)) |
                                (~inf_d_q & (upd_data_room > DATA_HALF)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cl_h_q  <= '0;
      cc_h_q  <= '0;
      cl_d_q  <= '0;
      cc_d_q  <= '0;
      inf_h_q <= 1'b0;
      inf_d_q <= 1'b0;
    end else if (init_i) begin
      cl_h_q  <= adv_hdr_i;
      cl_d_q  <= adv_data_i;
      cc_h_q  <= '0;
      cc_d_q  <= '0;
      inf_h_q <= (adv_hdr_i == '0);
      inf_d_q <= (adv_data_i == '0);
    end else begin
      cc_h_q <= cc_h_d;
      cc_d_q <= cc_d_d;
      if (update_i && !inf_h_q) cl_h_q <= adv_hdr_i;
      if (update_i && !inf_d_q) cl_d_q <= adv_data_i;
    end
  end

endmodule

// File: rtl/fc_tx_credit_gate.sv
// Transmit flow-control gate: tracks InitFC/UpdateFC credit per TLP type and
// grants at most one TLP per cycle when header and data credit suffice.
//   state     | meaning
//   FC_INIT   | waiting for InitFC of MWr, MRd and Cpl; no grants
//   FC_ACTIVE | UpdateFC honoured, TLPs granted against credit
module fc_tx_credit_gate
  import fc_tx_credit_gate_pkg::*;
#(
  parameter int HDR_W  = FC_HDR_W,
  parameter int DATA_W = FC_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              initfc_recv_i,
  input  logic              updatefc_recv_i,
  input  logic [1:0]        type_recv_i,
  input  logic [HDR_W-1:0]  hdr_credit_i,
  input  logic [DATA_W-1:0] data_credit_i,
  input  logic              tlp_valid_i,
  input  logic [1:0]        tlp_type_i,
  input  logic [DATA_W-1:0] tlp_data_cr_i,
  output logic              tlp_ready_o,
  output logic              fc_init_done_o,
  output logic              fc_err_o
);

  fc_state_e                state_q;
  logic [FC_NUM_TYPES-1:0]  init_seen_q;
  logic                     fc_err_q;

  logic                     adv_err, do_init, do_update, xfer;
  logic                     sel_hdr_ok, sel_data_ok;
  logic [DATA_W-1:0]        req_data;
  logic [FC_NUM_TYPES-1:0]  init_hit, update_hit, consume_hit;
  logic [FC_NUM_TYPES-1:0]  hdr_ok, data_ok, slot_err;

  always_comb begin
    adv_err   = (initfc_recv_i & updatefc_recv_i) |
                ((initfc_recv_i | updatefc_recv_i) & ~fc_type_valid(type_recv_i));
    do_init   = initfc_recv_i & ~updatefc_recv_i & (state_q == FC_INIT) &
                fc_type_valid(type_recv_i);
    do_update = updatefc_recv_i & ~initfc_recv_i & (state_q == FC_ACTIVE) &
                fc_type_valid(type_recv_i);
    // MRd carries no payload, so it never draws data credit.
    req_data  = (tlp_type_i == FC_MRD) ? '0 : tlp_data_cr_i;
  end

  for (genvar i = 0; i < FC_NUM_TYPES; i++) begin : g_slot
    assign init_hit[i]    = do_init & (type_recv_i == 2'(i));
    assign update_hit[i]  = do_update & (type_recv_i == 2'(i));
    assign consume_hit[i] = xfer & (tlp_type_i == 2'(i));

    fc_tx_credit_slot #(
      .HDR_W  (HDR_W),
      .DATA_W (DATA_W)
    ) u_slot (
      .clk          (clk),
      .rst_n        (rst_n),
      .init_i       (init_hit[i]),
      .update_i     (update_hit[i]),
      .consume_i    (consume_hit[i]),
      .adv_hdr_i    (hdr_credit_i),
      .adv_data_i   (data_credit_i),
      .req_data_i   (req_data),
      .hdr_ok_o     (hdr_ok[i]),
      .data_ok_o    (data_ok[i]),
      .update_err_o (slot_err[i])
    );
  end

  always_comb begin
    sel_hdr_ok  = 1'b0;
    sel_data_ok = 1'b0;
    for (int i = 0; i < FC_NUM_TYPES; i++) begin
      if (tlp_type_i == 2'(i)) begin
        sel_hdr_ok  = hdr_ok[i];
        sel_data_ok = data_ok[i];
      end
    end
    tlp_ready_o = (state_q == FC_ACTIVE) & fc_type_valid(tlp_type_i) & sel_hdr_ok &
                  (sel_data_ok | (tlp_type_i == FC_MRD));
    xfer        = tlp_valid_i & tlp_ready_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FC_INIT;
      init_seen_q <= '0;
      fc_err_q    <= 1'b0;
    end else begin
      init_seen_q <= init_seen_q | init_hit;
      fc_err_q    <= fc_err_q | adv_err | (|slot_err);
      case (state_q)
        FC_INIT:   if (&init_seen_q) state_q <= FC_ACTIVE;
        FC_ACTIVE: state_q <= FC_ACTIVE;
        default:   state_q <= FC_INIT;
      endcase
    end
  end

  assign fc_init_done_o = (state_q == FC_ACTIVE);
  assign fc_err_o       = fc_err_q;

endmodule

// File: tb/tb_fc_tx_credit_gate.sv
// Bench for fc_tx_credit_gate: directed scenarios plus randomized traffic,
// all checked every cycle against a credit-arithmetic reference model.
module tb_fc_tx_credit_gate;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        initfc = 1'b0, updatefc = 1'b0;
  logic [1:0]  type_recv = 2'b00;
  logic [7:0]  hdr_credit = '0;
  logic [11:0] data_credit = '0;
  logic        tlp_valid = 1'b0;
  logic [1:0]  tlp_type = 2'b00;
  logic [11:0] tlp_data = '0;
  logic        tlp_ready, init_done, fc_err;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference model: per-type limit/consumed counts as plain integers.
  int m_cl_h[3], m_cc_h[3], m_cl_d[3], m_cc_d[3];
  bit m_inf_h[3], m_inf_d[3], m_seen[3];
  bit m_active, m_err;

  fc_tx_credit_gate dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .initfc_recv_i   (initfc),
    .updatefc_recv_i (updatefc),
    .type_recv_i     (type_recv),
    .hdr_credit_i    (hdr_credit),
    .data_credit_i   (data_credit),
    .tlp_valid_i     (tlp_valid),
    .tlp_type_i      (tlp_type),
    .tlp_data_cr_i   (tlp_data),
    .tlp_ready_o     (tlp_ready),
    .fc_init_done_o  (init_done),
    .fc_err_o        (fc_err)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic act, logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cl_h[i] = 0; m_cc_h[i] = 0; m_cl_d[i] = 0; m_cc_d[i] = 0;
      m_inf_h[i] = 0; m_inf_d[i] = 0; m_seen[i] = 0;
    end
    m_active = 0;
    m_err = 0;
  endfunction

  function automatic bit model_ready(logic [1:0] t, logic [11:0] need);
    bit h_ok, d_ok;
    if (!m_active || t == 2'b11) return 1'b0;
    h_ok = m_inf_h[t] || (((m_cl_h[t] - m_cc_h[t] - 1) & 255) <= 128);
    d_ok = m_inf_d[t] || (t == 2'b01) ||
           (((m_cl_d[t] - m_cc_d[t] - int'(need)) & 4095) <= 2048);
    return h_ok && d_ok;
  endfunction

  initial begin : model_proc
    logic [1:0] t, a;
    bit go;
    int h, d;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        go = !m_active && m_seen[0] && m_seen[1] && m_seen[2];
        t = tlp_type;
        if (tlp_valid && model_ready(t, tlp_data)) begin
          m_cc_h[t] = (m_cc_h[t] + 1) & 255;
          if (t != 2'b01) m_cc_d[t] = (m_cc_d[t] + int'(tlp_data)) & 4095;
        end
        a = type_recv;
        h = int'(hdr_credit);
        d = int'(data_credit);
        if (initfc && updatefc) begin
          m_err = 1;
        end else if ((initfc || updatefc) && a == 2'b11) begin
          m_err = 1;
        end else if (initfc && !m_active) begin
          m_cl_h[a] = h; m_cl_d[a] = d; m_cc_h[a] = 0; m_cc_d[a] = 0;
          m_inf_h[a] = (h == 0); m_inf_d[a] = (d == 0); m_seen[a] = 1;
        end else if (updatefc && m_active) begin
          if (!m_inf_h[a]) begin
            if (((h - m_cc_h[a]) & 255) > 128) m_err = 1;
            m_cl_h[a] = h;
          end
          if (!m_inf_d[a]) begin
            if (((d - m_cc_d[a]) & 4095) > 2048) m_err = 1;
            m_cl_d[a] = d;
          end
        end
        if (go) m_active = 1;
      end
    end
  end

  initial begin : compare_proc
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("ready_vs_model", tlp_ready, model_ready(tlp_type, tlp_data));
        check("done_vs_model", init_done, m_active);
        check("err_vs_model", fc_err, m_err);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic req(bit v, logic [1:0] t, int d);
    tlp_valid = v;
    tlp_type  = t;
    tlp_data  = 12'(d);
  endtask

  task automatic adv(bit i, bit u, logic [1:0] t, int h, int d);
    initfc = i; updatefc = u; type_recv = t;
    hdr_credit = 8'(h); data_credit = 12'(d);
    cyc();
    initfc = 0; updatefc = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    req(0, 0, 0);
    cyc(); cyc();
    rst_n = 1;
  endtask

  task automatic init_all(int h0, int d0, int h1, int d1, int h2, int d2);
    adv(1, 0, 2'b00, h0, d0);
    adv(1, 0, 2'b01, h1, d1);
    adv(1, 0, 2'b10, h2, d2);
    cyc();
  endtask

  initial begin : stim
    int stalls, cl, r;
    logic [1:0] t;
    model_reset();
    repeat (3) cyc();
    neg();
    check("rst_ready", tlp_ready, 1'b0);
    check("rst_done", init_done, 1'b0);
    check("rst_err", fc_err, 1'b0);
    cyc();
    rst_n = 1;
    chk_en = 1;
    cyc();

    // 1: init sequence, done lags the last InitFC by one cycle.
    adv(1, 0, 2'b00, 4, 16);
    adv(1, 0, 2'b01, 2, 0);
    adv(1, 0, 2'b10, 0, 0);
    neg(); check("t1_done_lag", init_done, 1'b0);
    cyc();
    req(0, 2'b01, 100);
    neg(); check("t1_done", init_done, 1'b1); check("t1_mrd_inf", tlp_ready, 1'b1);
    cyc();
    req(0, 2'b10, 4000);
    neg(); check("t1_cpl_inf", tlp_ready, 1'b1);
    cyc();

    // 2: data-credit exhaustion and UpdateFC one-cycle latency.
    req(1, 2'b00, 8);
    neg(); check("t2_g1", tlp_ready, 1'b1); cyc();
    neg(); check("t2_g2", tlp_ready, 1'b1); cyc();
    neg(); check("t2_stall", tlp_ready, 1'b0); cyc();
    updatefc = 1; type_recv = 2'b00; hdr_credit = 8'd4; data_credit = 12'd24;
    neg(); check("t2_old_cl", tlp_ready, 1'b0); cyc();
    updatefc = 0;
    neg(); check("t2_after_upd", tlp_ready, 1'b1); cyc();
    req(0, 0, 0);

    // 3: header limit and always-granted Cpl.
    do_reset();
    init_all(4, 100, 2, 0, 0, 0);
    req(1, 2'b00, 1);
    for (int i = 0; i < 5; i++) begin
      neg(); check("t3_mwr_hdr", tlp_ready, i < 4); cyc();
    end
    for (int i = 0; i < 6; i++) begin
      req(1, 2'b10, int'($urandom_range(0, 4095)));
      neg(); check("t3_cpl", tlp_ready, 1'b1); cyc();
    end
    req(1, 2'b01, 50);
    for (int i = 0; i < 3; i++) begin
      neg(); check("t3_mrd_hdr", tlp_ready, i < 2); cyc();
    end

    // 4: header limit wraps through 250..4 while consuming.
    do_reset();
    init_all(8, 0, 1, 1, 1, 1);
    req(1, 2'b00, 5);
    stalls = 0;
    cl = 8;
    for (int k = 0; k < 260; k++) begin
      cl = (cl + 1) & 255;
      updatefc = 1; type_recv = 2'b00; hdr_credit = 8'(cl); data_credit = '0;
      neg();
      if (!tlp_ready) stalls++;
      cyc();
    end
    updatefc = 0;
    req(0, 0, 0);
    neg(); check("t4_no_stall", stalls == 0, 1'b1); check("t4_no_err", fc_err, 1'b0);
    cyc();

    // 5: ignored advertisements and reserved type.
    do_reset();
    adv(1, 0, 2'b00, 2, 2);
    adv(0, 1, 2'b00, 50, 50);
    neg(); check("t5_upd_init_noerr", fc_err, 1'b0); cyc();
    adv(1, 0, 2'b01, 3, 3);
    adv(1, 0, 2'b10, 3, 3);
    cyc();
    req(0, 2'b00, 3);
    neg(); check("t5_upd_ignored", tlp_ready, 1'b0); cyc();
    adv(1, 0, 2'b00, 0, 0);
    neg(); check("t5_init_ignored", tlp_ready, 1'b0); check("t5_init_noerr", fc_err, 1'b0);
    cyc();
    adv(0, 1, 2'b11, 5, 5);
    neg(); check("t5_type3_err", fc_err, 1'b1); check("t5_type3_nocl", tlp_ready, 1'b0);
    cyc();

    // 6: reset in the middle of traffic.
    adv(0, 1, 2'b00, 30, 300);
    for (int i = 0; i < 30; i++) begin
      req(($urandom % 4) != 0, ($urandom % 2) ? 2'b10 : 2'b00, int'($urandom_range(0, 8)));
      cyc();
    end
    req(1, 2'b00, 1);
    rst_n = 0;
    neg();
    check("t6_ready", tlp_ready, 1'b0);
    check("t6_done", init_done, 1'b0);
    check("t6_err", fc_err, 1'b0);
    cyc();
    rst_n = 1;
    neg(); check("t6_no_grant", tlp_ready, 1'b0); cyc();
    init_all(5, 5, 5, 5, 5, 5);
    neg(); check("t6_regrant", tlp_ready, 1'b1); cyc();

    // Randomized traffic, checked cycle by cycle by the model.
    for (int ph = 0; ph < 5; ph++) begin
      do_reset();
      for (int c = 0; c < 400; c++) begin
        r = int'($urandom % 64);
        initfc = 0; updatefc = 0;
        t = 2'($urandom % 4);
        type_recv = t;
        if (r < 4) begin
          initfc = 1;
          hdr_credit  = (($urandom % 4) == 0) ? 8'd0 : 8'($urandom_range(1, 40));
          data_credit = (($urandom % 4) == 0) ? 12'd0 : 12'($urandom_range(1, 200));
        end else if (r < 10) begin
          updatefc = 1;
          if (t != 2'b11 && r != 9) begin
            hdr_credit  = 8'(m_cc_h[t] + int'($urandom_range(0, 20)));
            data_credit = 12'(m_cc_d[t] + int'($urandom_range(0, 80)));
          end else begin
            hdr_credit  = 8'($urandom);
            data_credit = 12'($urandom);
          end
        end else if (r == 10) begin
          initfc = 1; updatefc = 1;
        end
        req(($urandom % 4) != 0, 2'($urandom % 4), int'($urandom_range(0, 16)));
        cyc();
      end
      initfc = 0; updatefc = 0;
    end

    req(0, 0, 0);
    cyc();
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
